// File: rtl/i2c_bus_monitor.sv
// ---------------------------------------------------------------------------
// i2c_bus_monitor
//
// Passive I2C bus observer. Both raw pins are synchronised into the clk
// domain, deglitched by a per-line hold counter, and then decoded into
// START / repeated START / STOP events, captured data bytes and the
// ACK/NACK bit that follows each byte.
//
// Optional feature (macro I2C_MON_TIMEOUT_EN): a bus-stuck watchdog that
// drops busy when no filtered SCL edge is seen for TIMEOUT_CYC clocks while
// a transfer is in progress. Without the macro, timeout is tied to 0.
//
// Parameters
//   FILT_LEN     clocks a synchronised line must hold a new level (1..15)
//   TIMEOUT_CYC  watchdog length in clocks (2..65535, macro builds only)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   scl, sda    raw I2C pins, asynchronous to clk
//   start       1-clock pulse on any START (including repeated START)
//   rep_start   1-clock pulse on a START seen while busy
//   stop        1-clock pulse on STOP
//   busy        high from START until STOP (or timeout)
//   data_out    last captured byte, MSB first on the wire
//   byte_valid  1-clock pulse when data_out updates
//   ack         last 9th-bit value, 1 = ACK (SDA low)
//   ack_valid   1-clock pulse when ack updates
//   timeout     1-clock pulse on bus-stuck timeout
//
// All event outputs are registered: an event decoded from the filtered
// lines in one cycle appears on the outputs after the next rising edge.
// ---------------------------------------------------------------------------
module i2c_bus_monitor #(
    parameter int FILT_LEN    = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       sda,
    output logic       start,
    output logic       rep_start,
    output logic       stop,
    output logic       busy,
    output logic [7:0] data_out,
    output logic       byte_valid,
    output logic       ack,
    output logic       ack_valid,
    output logic       timeout
);

    localparam logic [3:0] LP_FILT_LAST = 4'(FILT_LEN - 1);

    // Synchronisers (reset to 1 = idle bus)
    logic       r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    // Deglitch filters
    logic       r_scl_f, r_sda_f;
    logic [3:0] r_scl_cnt, r_sda_cnt;
    // Previous-cycle copies of the filtered lines
    logic       r_scl_p, r_sda_p;
    // Decoder state and registered outputs
    logic       r_start, r_rep_start, r_stop, r_busy;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift, r_data;
    logic       r_byte_valid, r_ack, r_ack_valid;

    logic       w_start, w_stop, w_scl_rise, w_scl_edge, w_timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= scl;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= sda;
            r_sda_s2 <= r_sda_s1;
        end
    end

    // The filtered level flips on the clock where the disagreement count
    // would reach FILT_LEN, so a level must persist FILT_LEN clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_f   <= 1'b1;
            r_scl_cnt <= 4'd0;
        end else if (r_scl_s2 == r_scl_f) begin
            r_scl_cnt <= 4'd0;
        end else if (r_scl_cnt == LP_FILT_LAST) begin
            r_scl_f   <= r_scl_s2;
            r_scl_cnt <= 4'd0;
        end else begin
            r_scl_cnt <= r_scl_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sda_f   <= 1'b1;
            r_sda_cnt <= 4'd0;
        end else if (r_sda_s2 == r_sda_f) begin
            r_sda_cnt <= 4'd0;
        end else if (r_sda_cnt == LP_FILT_LAST) begin
            r_sda_f   <= r_sda_s2;
            r_sda_cnt <= 4'd0;
        end else begin
            r_sda_cnt <= r_sda_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_p <= 1'b1;
            r_sda_p <= 1'b1;
        end else begin
            r_scl_p <= r_scl_f;
            r_sda_p <= r_sda_f;
        end
    end

    // Requiring SCL high in both cycles rejects simultaneous SCL/SDA moves.
    assign w_start    = r_scl_p & r_scl_f &  r_sda_p & ~r_sda_f;
    assign w_stop     = r_scl_p & r_scl_f & ~r_sda_p &  r_sda_f;
    assign w_scl_rise = ~r_scl_p & r_scl_f;
    assign w_scl_edge = r_scl_p ^ r_scl_f;

`ifdef I2C_MON_TIMEOUT_EN
    localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_to_cnt;
    logic        r_timeout;

    // START/STOP take priority over an expiring watchdog in the same cycle.
    assign w_timeout_hit = r_busy & ~w_start & ~w_stop & ~w_scl_edge &
                           (r_to_cnt == LP_TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit;
            if (!r_busy || w_start || w_stop || w_scl_edge || w_timeout_hit) begin
                r_to_cnt <= 16'd0;
            end else begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    localparam logic [15:0] LP_TO_CFG = 16'(TIMEOUT_CYC);

    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = ^LP_TO_CFG;
    assign w_timeout_hit        = 1'b0;
    assign timeout              = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start      <= 1'b0;
            r_rep_start  <= 1'b0;
            r_stop       <= 1'b0;
            r_busy       <= 1'b0;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'h00;
            r_data       <= 8'h00;
            r_byte_valid <= 1'b0;
            r_ack        <= 1'b0;
            r_ack_valid  <= 1'b0;
        end else begin
            r_start      <= w_start;
            r_rep_start  <= w_start & r_busy;
            r_stop       <= w_stop;
            r_byte_valid <= 1'b0;
            r_ack_valid  <= 1'b0;

            if (w_start) begin
                r_busy <= 1'b1;
            end else if (w_stop || w_timeout_hit) begin
                r_busy <= 1'b0;
            end

            // A START, STOP or timeout discards any partial byte.
            if (w_start || w_stop || w_timeout_hit) begin
                r_bit_cnt <= 4'd0;
                r_shift   <= 8'h00;
            end else if (r_busy && w_scl_rise) begin
                if (r_bit_cnt == 4'd8) begin
                    r_ack       <= ~r_sda_f;
                    r_ack_valid <= 1'b1;
                    r_bit_cnt   <= 4'd0;
                end else begin
                    r_shift   <= {r_shift[6:0], r_sda_f};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        r_data       <= {r_shift[6:0], r_sda_f};
                        r_byte_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign start      = r_start;
    assign rep_start  = r_rep_start;
    assign stop       = r_stop;
    assign busy       = r_busy;
    assign data_out   = r_data;
    assign byte_valid = r_byte_valid;
    assign ack        = r_ack;
    assign ack_valid  = r_ack_valid;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_monitor
//
// Directed bench for i2c_bus_monitor (FILT_LEN=3, TIMEOUT_CYC=100).
// SCL is generated at clk/16. A negedge monitor counts event pulses and
// checks every captured byte / ACK against expected queues filled by the
// stimulus sequence.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_bus_monitor;

    logic       clk;
    logic       rst_n;
    logic       scl;
    logic       sda;
    logic       start, rep_start, stop, busy;
    logic [7:0] data_out;
    logic       byte_valid, ack, ack_valid, timeout;

    int n_total = 0;
    int n_bad   = 0;

    int cnt_start = 0;
    int cnt_rep   = 0;
    int cnt_stop  = 0;
    int cnt_to    = 0;
    int cnt_bytes = 0;
    int cnt_acks  = 0;

    logic [7:0] exp_q[$];
    logic [0:0] exp_ack_q[$];

    i2c_bus_monitor #(
        .FILT_LEN   (3),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda       (sda),
        .start     (start),
        .rep_start (rep_start),
        .stop      (stop),
        .busy      (busy),
        .data_out  (data_out),
        .byte_valid(byte_valid),
        .ack       (ack),
        .ack_valid (ack_valid),
        .timeout   (timeout)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (start)     cnt_start++;
        if (rep_start) cnt_rep++;
        if (stop)      cnt_stop++;
        if (timeout)   cnt_to++;
        if (byte_valid) begin
            cnt_bytes++;
            if (exp_q.size() == 0) check_eq("byte_extra", {24'd0, data_out}, 32'hffff_ffff);
            else                   check_eq("byte", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        end
        if (ack_valid) begin
            cnt_acks++;
            if (exp_ack_q.size() == 0) check_eq("ack_extra", {31'd0, ack}, 32'hffff_ffff);
            else                       check_eq("ack", {31'd0, ack}, {31'd0, exp_ack_q.pop_front()});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        cnt_start = 0;
        cnt_rep   = 0;
        cnt_stop  = 0;
        cnt_to    = 0;
        cnt_bytes = 0;
        cnt_acks  = 0;
    endtask

    // From idle (both high): SDA falls while SCL high, then SCL falls.
    task automatic bus_start();
        scl = 1'b1; sda = 1'b1; wait_clks(8);
        sda = 1'b0;             wait_clks(8);
        scl = 1'b0;             wait_clks(4);
    endtask

    // From SCL low: release SDA, raise SCL, then START.
    task automatic bus_rep_start();
        sda = 1'b1; wait_clks(4);
        scl = 1'b1; wait_clks(8);
        sda = 1'b0; wait_clks(8);
        scl = 1'b0; wait_clks(4);
    endtask

    task automatic bus_bit(input logic b);
        sda = b;    wait_clks(4);
        scl = 1'b1; wait_clks(8);
        scl = 1'b0; wait_clks(4);
    endtask

    task automatic bus_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bus_bit(b[i]);
    endtask

    task automatic bus_stop();
        sda = 1'b0; wait_clks(4);
        scl = 1'b1; wait_clks(8);
        sda = 1'b1; wait_clks(20);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        scl   = 1'b1;
        sda   = 1'b1;
        wait_clks(3);
        @(negedge clk);
        check_eq("rst_flags", {24'd0, start, rep_start, stop, busy, byte_valid, ack, ack_valid, timeout}, 32'd0);
        check_eq("rst_data", {24'd0, data_out}, 32'd0);

        // Reset release with idle bus: nothing happens.
        rst_n = 1'b1;
        wait_clks(20);
        check_eq("idle_start", cnt_start, 0);
        check_eq("idle_stop", cnt_stop, 0);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);

        // START latency: 2 sync + 3 filter + 1 output register = 6 edges.
        clear_counts();
        sda = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("lat_early", {31'd0, start}, 32'd0);
        @(negedge clk);
        check_eq("lat_start", {31'd0, start}, 32'd1);
        wait_clks(10);
        sda = 1'b1;
        wait_clks(20);
        check_eq("lat_stop", cnt_stop, 1);
        check_eq("lat_busy", {31'd0, busy}, 32'd0);

        // START, 0xA5, ACK, STOP.
        clear_counts();
        exp_q.push_back(8'hA5);
        exp_ack_q.push_back(1'b1);
        bus_start();
        check_eq("a5_busy_mid", {31'd0, busy}, 32'd1);
        bus_byte(8'hA5);
        bus_bit(1'b0);
        bus_stop();
        check_eq("a5_start", cnt_start, 1);
        check_eq("a5_rep", cnt_rep, 0);
        check_eq("a5_stop", cnt_stop, 1);
        check_eq("a5_bytes", cnt_bytes, 1);
        check_eq("a5_acks", cnt_acks, 1);
        check_eq("a5_busy_end", {31'd0, busy}, 32'd0);

        // START, 0x3C, NACK, repeated START, 0x81, ACK, STOP.
        clear_counts();
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h81);
        exp_ack_q.push_back(1'b0);
        exp_ack_q.push_back(1'b1);
        bus_start();
        bus_byte(8'h3C);
        bus_bit(1'b1);
        bus_rep_start();
        check_eq("rs_rep_mid", cnt_rep, 1);
        bus_byte(8'h81);
        bus_bit(1'b0);
        bus_stop();
        check_eq("rs_start", cnt_start, 2);
        check_eq("rs_rep", cnt_rep, 1);
        check_eq("rs_stop", cnt_stop, 1);
        check_eq("rs_bytes", cnt_bytes, 2);
        check_eq("rs_data", {24'd0, data_out}, 32'h81);

        // SDA glitches with SCL high: 2 clocks rejected, 3 clocks passed.
        clear_counts();
        sda = 1'b0; wait_clks(2);
        sda = 1'b1; wait_clks(20);
        check_eq("glitch2_start", cnt_start, 0);
        check_eq("glitch2_busy", {31'd0, busy}, 32'd0);
        sda = 1'b0; wait_clks(3);
        sda = 1'b1; wait_clks(20);
        check_eq("glitch3_start", cnt_start, 1);

        // SCL and SDA move together: neither START nor STOP.
        clear_counts();
        scl = 1'b0; sda = 1'b0; wait_clks(20);
        check_eq("both_busy", {31'd0, busy}, 32'd0);
        scl = 1'b1; sda = 1'b1; wait_clks(20);
        check_eq("both_start", cnt_start, 0);
        check_eq("both_stop", cnt_stop, 0);

        // START then SCL stuck low.
        clear_counts();
        bus_start();
        wait_clks(300);
`ifdef I2C_MON_TIMEOUT_EN
        check_eq("stuck_to", cnt_to, 1);
        check_eq("stuck_busy", {31'd0, busy}, 32'd0);
        check_eq("stuck_nostop", cnt_stop, 0);
`else
        check_eq("stuck_to", cnt_to, 0);
        check_eq("stuck_busy", {31'd0, busy}, 32'd1);
`endif
        bus_stop();
        check_eq("stuck_release", {31'd0, busy}, 32'd0);

        // Reset mid-byte, then a clean 0x5A transfer.
        clear_counts();
        bus_start();
        bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b1);
        rst_n = 1'b0;
        scl   = 1'b1;
        sda   = 1'b1;
        wait_clks(3);
        @(negedge clk);
        check_eq("mid_rst_flags", {24'd0, start, rep_start, stop, busy, byte_valid, ack, ack_valid, timeout}, 32'd0);
        check_eq("mid_rst_data", {24'd0, data_out}, 32'd0);
        rst_n = 1'b1;
        wait_clks(20);
        check_eq("post_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("post_rst_bytes", cnt_bytes, 0);
        exp_q.push_back(8'h5A);
        exp_ack_q.push_back(1'b1);
        bus_start();
        bus_byte(8'h5A);
        bus_bit(1'b0);
        bus_stop();
        check_eq("5a_data", {24'd0, data_out}, 32'h5A);
        check_eq("5a_bytes", cnt_bytes, 1);

        check_eq("exp_q_empty", exp_q.size(), 0);
        check_eq("exp_ack_q_empty", exp_ack_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_bus_monitor.md
I2C_BUS_MONITOR -- requirements
Module: i2c_bus_monitor

Interface
REQ-001 SHALL have parameter FILT_LEN, default 3: consecutive clocks a synchronised line must hold a new level before the filtered level follows (legal 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096: clocks without a filtered SCL edge while busy before timeout (legal 2..65535; used only with I2C_MON_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port scl  input  1  raw I2C SCL pin, asynchronous to clk.
REQ-006 SHALL have port sda  input  1  raw I2C SDA pin, asynchronous to clk.
REQ-007 SHALL have port start  output  1  one-clock pulse on any START, including a repeated START.
REQ-008 SHALL have port rep_start  output  1  one-clock pulse on a START detected while busy=1.
REQ-009 SHALL have port stop  output  1  one-clock pulse on STOP.
REQ-010 SHALL have port busy  output  1  level, high from START until STOP or timeout.
REQ-011 SHALL have port data_out  output  8  last captured byte, MSB first on the wire.
REQ-012 SHALL have port byte_valid  output  1  one-clock pulse when data_out is updated.
REQ-013 SHALL have port ack  output  1  last 9th-bit value, 1 = ACK (SDA low).
REQ-014 SHALL have port ack_valid  output  1  one-clock pulse when ack is updated.
REQ-015 SHALL have port timeout  output  1  one-clock pulse on bus-stuck timeout.

Function
REQ-016 SHALL pass scl and sda each through a 2-flop synchroniser.
REQ-017 SHALL filter each line with a per-line counter: counter increments while the synchronised value differs from the filtered value, and clears when they match; the filtered value flips and the counter clears when the counter reaches FILT_LEN. A pulse shorter than FILT_LEN clocks is never passed.
REQ-018 SHALL keep previous-cycle copies scl_p and sda_p of the filtered lines scl_f and sda_f.
REQ-019 SHALL detect START when sda_p=1, sda_f=0, scl_p=1 and scl_f=1. Outputs start (and rep_start if busy was 1) on the next clock edge.
REQ-020 SHALL detect STOP when sda_p=0, sda_f=1, scl_p=1 and scl_f=1. Outputs stop and clears busy on the next clock edge.
REQ-021 SHALL NOT report START or STOP when scl_f changes in the same cycle as sda_f.
REQ-022 SHALL set busy on START. On STOP, busy SHALL be cleared even if busy was already 0.
REQ-023 SHALL clear the bit counter (0..8) on START or repeated START; the counter SHALL NOT advance while busy=0.
REQ-024 SHALL, on a filtered SCL rising edge with busy=1 and counter<8, shift sda_f into the shift register LSB and increment the counter. When the counter becomes 8, the same edge SHALL load data_out and pulse byte_valid.
REQ-025 SHALL, on a filtered SCL rising edge with busy=1 and counter=8, set ack=~sda_f, pulse ack_valid and return the counter to 0.
REQ-026 SHALL discard a partial byte on STOP or START, with no byte_valid.
REQ-027 SHALL produce an output pulse 2 + FILT_LEN + 1 clocks after the raw pin transition, when the pin holds steady for that period.

Reset
REQ-028 SHALL, while rst_n=0, set synchroniser flops, filtered lines, scl_p and sda_p to 1 (idle bus), and filter counters, bit counter and shift register to 0.
REQ-029 SHALL, while rst_n=0, hold every output at 0, including data_out=8'h00 and ack=0.
REQ-030 SHALL NOT produce a START, STOP or byte event solely because rst_n deasserts while the bus is idle.
REQ-031 SHALL abandon any transfer when rst_n asserts mid-transfer; after release, busy SHALL stay 0 until the next START.

Configuration
REQ-032 SHALL, with macro I2C_MON_TIMEOUT_EN defined, have a 16-bit counter that runs while busy=1 and clears on any filtered SCL edge, on START and on STOP. When it reaches TIMEOUT_CYC-1, it SHALL pulse timeout, clear busy and clear the bit counter, with no stop pulse.
REQ-033 SHALL, with I2C_MON_TIMEOUT_EN undefined, drive timeout constant 0 with no counter logic; busy SHALL clear only on STOP or reset.

Verification
REQ-034 SHALL pass: START, byte 0xA5, ACK, STOP at SCL = clk/16 -> start=1, busy=1, byte_valid with data_out=0xA5, ack_valid with ack=1, stop=1, busy=0; no rep_start.
REQ-035 SHALL pass: START, byte 0x3C, NACK (SDA high), repeated START, byte 0x81, STOP -> data_out=0x3C then ack=0, then start=1 and rep_start=1, then data_out=0x81.
REQ-036 SHALL pass: 2-clock SDA low glitch with SCL high, FILT_LEN=3 -> no start; 3-clock glitch -> start pulse.
REQ-037 SHALL pass: SCL and SDA driven low in the same clock from idle -> no start, busy stays 0.
REQ-038 SHALL pass: with I2C_MON_TIMEOUT_EN and TIMEOUT_CYC=100, START then SCL held low -> exactly one timeout pulse 100 clocks after the last filtered SCL edge, busy=0; without the macro -> timeout stays 0 and busy stays 1.
REQ-039 SHALL pass: rst_n pulsed low after 4 data bits -> all outputs 0; a following full byte 0x5A after a new START -> data_out=0x5A.
